fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset (bits[1:0] zero).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: instruction/address width; only 32 supported.
REQ-003 SHALL use a single clock and a synchronous, active-high reset:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have the following pipeline-control ports:
- StallF, input, 1: decode register not accepting; hold presented entry.
- PCSrcE, input, 1: redirect request from execute.
- PCTargetE, input, 32: redirect address.
REQ-005 SHALL have the following instruction-memory ports:
- imem_req, output, 1: request valid.
- imem_addr, output, 32: word-aligned request address.
- imem_gnt, input, 1: request accepted this cycle.
- imem_rvalid, input, 1: response valid.
- imem_rdata, input, 32: response instruction.
REQ-006 SHALL have the following outputs to the IF/ID register:
- instrF, output, 32: fetched instruction.
- PCF, output, 32: its address.
- PCPlus4F, output, 32: PCF+4.
- FetchValidF, output, 1: outputs hold a real instruction.

Function
REQ-007 SHALL keep at most one imem request outstanding (granted, response not yet received).
REQ-008 SHALL implement states S_REQ, S_WAIT, S_DROP:
- S_REQ: imem_req=1 only when (!buf_valid || !StallF); on gnt latch inflight_pc=pc_q, pc_q+=4, go S_WAIT.
- S_WAIT: imem_req=0; on rvalid load buffer, go S_REQ.
- S_DROP: imem_req=0; on rvalid discard data, go S_REQ.
REQ-009 SHALL, on response in S_WAIT, set buf_valid=1, buf_instr=imem_rdata, buf_pc=inflight_pc at the same edge.
REQ-010 SHALL drive instrF=buf_instr, PCF=buf_pc, PCPlus4F=buf_pc+4 (mod 2^32) when buf_valid=1; all three 32'h0 when buf_valid=0.
REQ-011 SHALL drive FetchValidF=buf_valid.
REQ-012 SHALL consume the buffer (buf_valid cleared) at an edge where buf_valid=1 and StallF=0, unless reloaded at that same edge (REQ-009 wins).
REQ-013 SHALL drive imem_addr=pc_q whenever imem_req=1, and SHALL hold imem_req and imem_addr stable until imem_gnt.
REQ-014 SHALL, on PCSrcE=1, at that edge:
- set pc_q={PCTargetE[31:2],2'b00};
- clear buf_valid.
Redirect has priority over StallF.
REQ-015 SHALL, on redirect with a request outstanding and no rvalid that cycle, go S_DROP.
REQ-016 SHALL, on redirect coinciding with rvalid in S_WAIT, discard the data and go S_REQ.
REQ-017 SHALL, on redirect coinciding with gnt in S_REQ, treat the granted request as stale, leave pc_q at the target (no +4), and go S_DROP.
REQ-018 SHALL, on redirect in S_DROP, stay in S_DROP with the new pc_q.
REQ-019 SHALL have an instruction-to-output latency of gnt-to-rvalid latency plus one edge (registered buffer); no combinational path from imem_rdata to instrF.
REQ-020 SHALL wrap pc_q from 32'hFFFF_FFFC to 32'h0000_0000 without error.

Reset
REQ-021 SHALL, while rst=1 at an edge, set:
- state=S_REQ, pc_q=RESET_PC, buf_valid=0, buf_instr=0, buf_pc=0, inflight_pc=0.
rst overrides PCSrcE and imem inputs.
REQ-022 SHALL hold imem_req=0 during any cycle where rst=1, and SHALL issue the first request in the first cycle after rst deasserts.
REQ-023 SHALL ignore a response arriving after a reset taken mid-request (memory is reset together with this block).

Configuration
REQ-024 SHALL, with FETCH_PERF_CNT_EN defined, add these ports, both reset to 0 and wrapping at 2^32:
- perf_fetch_cnt, output, 32: increments per buffer load.
- perf_drop_cnt, output, 32: increments per discarded response (S_DROP or REQ-016).
REQ-025 SHALL, without FETCH_PERF_CNT_EN, have neither port nor counter logic, with identical behaviour otherwise.

Verification
REQ-026 SHALL cover reset then zero-wait memory (gnt=1, rvalid next cycle), StallF=0 -> PCF sequence 0,4,8 with FetchValidF=1, one instruction per two cycles.
REQ-027 SHALL cover buffer holding 0x00500093 at PC 8 with StallF=1 for 3 cycles -> outputs stable, imem_req=0, resumes PC 12 after release.
REQ-028 SHALL cover redirect PCTargetE=0x0000_0102 while in S_WAIT -> next rvalid discarded, next imem_addr=0x0000_0100, FetchValidF=0 until its response.
REQ-029 SHALL cover PCSrcE coinciding with imem_gnt for addr 0x10 -> state S_DROP, pc_q=target, stale response not presented; perf_drop_cnt=1 when enabled.
REQ-030 SHALL cover rst asserted in S_WAIT with buf_valid=1 -> next cycle all outputs 0, imem_req=0; then first request at RESET_PC.
REQ-031 SHALL cover pc_q=0xFFFF_FFFC fetched -> PCPlus4F=0x0000_0000, next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding-request imem master feeding a single-entry IF/ID buffer.
// Define FETCH_PERF_CNT_EN to add the perf_fetch_cnt / perf_drop_cnt counters.
module fetch_stage #(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter logic [31:0]  RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  StallF,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,

    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,

    output logic [DATA_WIDTH-1:0] instrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  FetchValidF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] inflight_pc_q;
    logic [DATA_WIDTH-1:0] buf_instr_q;
    logic [DATA_WIDTH-1:0] buf_pc_q;
    logic                  buf_valid_q;

    logic                  fire;
    logic                  load;
    logic                  drop;
    logic [DATA_WIDTH-1:0] target_aligned;
    logic                  unused_target_lsbs;

    assign target_aligned     = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
    assign unused_target_lsbs = ^PCTargetE[1:0];

    // Hold off a new request while a stalled entry is still sitting in the buffer.
    assign imem_req  = !rst && (state_q == S_REQ) && (!buf_valid_q || !StallF);
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_gnt;

    assign load = (state_q == S_WAIT) && imem_rvalid && !PCSrcE;
    assign drop = imem_rvalid && ((state_q == S_DROP) || ((state_q == S_WAIT) && PCSrcE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (fire) begin
                        inflight_pc_q <= pc_q;
                        state_q       <= PCSrcE ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end else if (PCSrcE) begin
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase

            if (PCSrcE) begin
                pc_q <= target_aligned;
            end else if (fire) begin
                pc_q <= pc_q + DATA_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else if (PCSrcE) begin
            buf_valid_q <= 1'b0;
        end else if (load) begin
            buf_valid_q <= 1'b1;
            buf_instr_q <= imem_rdata;
            buf_pc_q    <= inflight_pc_q;
        end else if (buf_valid_q && !StallF) begin
            buf_valid_q <= 1'b0;
        end
    end

    assign instrF      = buf_valid_q ? buf_instr_q : '0;
    assign PCF         = buf_valid_q ? buf_pc_q : '0;
    assign PCPlus4F    = buf_valid_q ? (buf_pc_q + DATA_WIDTH'(4)) : '0;
    assign FetchValidF = buf_valid_q;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (drop) perf_drop_cnt  <= perf_drop_cnt + 32'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small variable-latency instruction memory model.
// Define FETCH_PERF_CNT_EN to also check the perf counters.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        FetchValidF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Memory model: grant while idle, respond lat cycles after the grant.
    logic        gnt_en;
    int unsigned lat;
    logic        busy = 1'b0;
    int unsigned cnt  = 0;
    logic [31:0] paddr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h8) ? 32'h0050_0093 : ~a;
    endfunction

    assign imem_gnt    = gnt_en && !busy;
    assign imem_rvalid = busy && (cnt == 1);
    assign imem_rdata  = imem_rvalid ? mem_word(paddr) : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (busy) begin
            if (cnt == 1) busy <= 1'b0;
            else          cnt  <= cnt - 1;
        end else if (imem_req && imem_gnt) begin
            busy  <= 1'b1;
            cnt   <= lat;
            paddr <= imem_addr;
        end
    end

    always #5 clk = ~clk;

    fetch_stage #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instrF     (instrF),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .FetchValidF(FetchValidF)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_drop_cnt (perf_drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] ins, input logic [31:0] pc4);
        check({tag, ".valid"}, 32'(FetchValidF), 32'(v));
        check({tag, ".pc"},    PCF,      pc);
        check({tag, ".instr"}, instrF,   ins);
        check({tag, ".pc4"},   PCPlus4F, pc4);
    endtask

    task automatic check_req(input string tag, input logic r, input logic [31:0] a);
        check({tag, ".req"}, 32'(imem_req), 32'(r));
        if (r) check({tag, ".addr"}, imem_addr, a);
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        gnt_en = 1'b1; lat = 1;
        step();
        step();
        check_out("rst", 1'b0, 32'h0, 32'h0, 32'h0);
        check_req("rst", 1'b0, 32'h0);
        rst = 1'b0;
        #1;

        // Zero-wait memory: one instruction every two cycles.
        check_req("first_req", 1'b1, 32'h0);
        step();
        check_req("wait0", 1'b0, 32'h0);
        check_out("wait0", 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check_out("pc0", 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h4);
        check_req("pc0", 1'b1, 32'h4);
        step();
        check_out("gap", 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check_out("pc4", 1'b1, 32'h4, 32'hFFFF_FFFB, 32'h8);
        step();
        step();
        check_out("pc8", 1'b1, 32'h8, 32'h0050_0093, 32'hC);

        // Stall holds the buffer and suppresses requests.
        StallF = 1'b1;
        #1;
        check_req("stall_now", 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall", 1'b1, 32'h8, 32'h0050_0093, 32'hC);
            check_req("stall", 1'b0, 32'h0);
        end
        StallF = 1'b0;
        #1;
        check_req("release", 1'b1, 32'hC);
        step();
        check_out("release_gap", 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check_out("pc12", 1'b1, 32'hC, 32'hFFFF_FFF3, 32'h10);

        // Redirect while waiting on a slow response: response dropped.
        lat = 3;
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
        step();
        PCSrcE = 1'b0;
        check_out("drop0", 1'b0, 32'h0, 32'h0, 32'h0);
        check_req("drop0", 1'b0, 32'h0);
        step();
        check_req("drop1", 1'b0, 32'h0);
        lat = 1;
        step();
        check_out("drop2", 1'b0, 32'h0, 32'h0, 32'h0);
        check_req("redir_req", 1'b1, 32'h100);
        step();
        check_out("redir_wait", 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check_out("pc100", 1'b1, 32'h100, 32'hFFFF_FEFF, 32'h104);
`ifdef FETCH_PERF_CNT_EN
        check("perf_drop_a", perf_drop_cnt, 32'd1);
        check("perf_fetch_a", perf_fetch_cnt, 32'd5);
`endif

        // Redirect coinciding with grant for 0x10: granted request is stale.
        gnt_en = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h10;
        step();
        check_out("to10", 1'b0, 32'h0, 32'h0, 32'h0);
        check_req("to10", 1'b1, 32'h10);
        gnt_en = 1'b1; PCTargetE = 32'h40;
        step();
        PCSrcE = 1'b0;
        check_req("stale_drop", 1'b0, 32'h0);
        check_out("stale_drop", 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check_req("after_stale", 1'b1, 32'h40);
        check_out("after_stale", 1'b0, 32'h0, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_drop_b", perf_drop_cnt, 32'd2);
`endif
        step();
        step();
        check_out("pc40", 1'b1, 32'h40, 32'hFFFF_FFBF, 32'h44);

        // Reset with a valid buffer.
        StallF = 1'b1; rst = 1'b1;
        #1;
        check_req("rst_mid", 1'b0, 32'h0);
        step();
        check_out("rst_mid", 1'b0, 32'h0, 32'h0, 32'h0);
        check_req("rst_mid_q", 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch_rst", perf_fetch_cnt, 32'd0);
        check("perf_drop_rst", perf_drop_cnt, 32'd0);
`endif
        rst = 1'b0; StallF = 1'b0;
        #1;
        check_req("rst_first", 1'b1, 32'h0);

        // Redirect to the top word (low target bits masked) and wrap.
        gnt_en = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
        step();
        PCSrcE = 1'b0; gnt_en = 1'b1;
        #1;
        check_req("top_req", 1'b1, 32'hFFFF_FFFC);
        step();
        step();
        check_out("top", 1'b1, 32'hFFFF_FFFC, 32'h0000_0003, 32'h0);
        check_req("wrap_req", 1'b1, 32'h0);

        // Redirect coinciding with response in S_WAIT: data discarded.
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        step();
        PCSrcE = 1'b0;
        #1;
        check_out("redir_rvalid", 1'b0, 32'h0, 32'h0, 32'h0);
        check_req("redir_rvalid", 1'b1, 32'h200);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch_c", perf_fetch_cnt, 32'd1);
        check("perf_drop_c", perf_drop_cnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
